// File: rtl/fetch_queue.sv
// Instruction fetch queue: fetches sequential words from a combinational
// instruction memory into a circular buffer and offers the head to IF/ID.
module fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic [15:0]              imem_addr,
  input  logic [31:0]              imem_data,
  input  logic                     redirect,
  input  logic [15:0]              redirect_pc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_inst,
  output logic [15:0]              out_pc_plus1,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef struct packed {
    logic [31:0] inst;
    logic [15:0] pc_plus1;
  } entry_t;

  logic [15:0]   fpc_q, fpc_d, fpc_plus1;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  entry_t        mem_q [DEPTH];
  logic          push, pop;

  // 16-bit add drops the carry, so 16'hFFFF + 1 wraps to 16'h0000.
  assign fpc_plus1 = fpc_q + 16'd1;

  assign out_valid = (count_q != '0) & ~redirect;
  assign pop       = out_valid & out_ready;
  // A pop frees a slot in the same cycle, so a full queue keeps streaming.
  assign push      = ~redirect & ((count_q < FULL) | pop);

  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    fpc_d    = fpc_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (redirect) begin
      fpc_d    = redirect_pc;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        fpc_d    = fpc_plus1;
        wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fpc_q    <= RESET_PC;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      fpc_q    <= fpc_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: entry storage has no reset; count gates validity, so stale data is never offered.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {imem_data, fpc_plus1};
  end

  assign imem_addr    = fpc_q;
  assign out_inst     = mem_q[rd_ptr_q].inst;
  assign out_pc_plus1 = mem_q[rd_ptr_q].pc_plus1;
  assign count        = count_q;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: a vector table for the main stream plus
// hand-written sequences for redirect, async reset and full-queue streaming.
module tb_fetch_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        out_ready;

  logic [15:0] imem_addr, w_imem_addr;
  logic [31:0] imem_data, w_imem_data;
  logic        out_valid, w_out_valid;
  logic [31:0] out_inst, w_out_inst;
  logic [15:0] out_pc_plus1, w_out_pc_plus1;
  logic [2:0]  count, w_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Instruction memory model: imem[a] = 32'h1000_0000 + a.
  assign imem_data   = 32'h1000_0000 + {16'h0000, imem_addr};
  assign w_imem_data = 32'h1000_0000 + {16'h0000, w_imem_addr};

  fetch_queue #(.DEPTH(4), .RESET_PC(16'h0000)) dut (
    .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_data(imem_data),
    .redirect(redirect), .redirect_pc(redirect_pc), .out_valid(out_valid),
    .out_ready(out_ready), .out_inst(out_inst), .out_pc_plus1(out_pc_plus1),
    .count(count)
  );

  fetch_queue #(.DEPTH(4), .RESET_PC(16'hFFFE)) dut_w (
    .clk(clk), .rst(rst), .imem_addr(w_imem_addr), .imem_data(w_imem_data),
    .redirect(redirect), .redirect_pc(redirect_pc), .out_valid(w_out_valid),
    .out_ready(out_ready), .out_inst(w_out_inst), .out_pc_plus1(w_out_pc_plus1),
    .count(w_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        redirect;
    logic [15:0] rpc;
    logic        rdy;
    logic        valid;
    logic [31:0] inst;
    logic [15:0] pc1;
    logic [2:0]  cnt;
    logic [15:0] addr;
  } vec_t;

  function automatic vec_t mk(logic rd, logic [15:0] rpc, logic rdy, logic v,
                              logic [31:0] inst, logic [15:0] pc1, logic [2:0] cnt,
                              logic [15:0] addr);
    vec_t r;
    r.redirect = rd; r.rpc = rpc; r.rdy = rdy; r.valid = v;
    r.inst = inst; r.pc1 = pc1; r.cnt = cnt; r.addr = addr;
    return r;
  endfunction

  vec_t        vecs [16];
  logic [15:0] w_addr [4];
  logic [15:0] w_pc1  [4];

  initial begin
    // Each vector: inputs applied after a falling edge, outputs checked 1 time unit later.
    vecs[0]  = mk(0, 16'h0000, 1, 0, 32'h0,         16'h0000, 3'd0, 16'h0000);
    vecs[1]  = mk(0, 16'h0000, 1, 1, 32'h1000_0000, 16'h0001, 3'd1, 16'h0001);
    vecs[2]  = mk(0, 16'h0000, 1, 1, 32'h1000_0001, 16'h0002, 3'd1, 16'h0002);
    vecs[3]  = mk(0, 16'h0000, 1, 1, 32'h1000_0002, 16'h0003, 3'd1, 16'h0003);
    vecs[4]  = mk(0, 16'h0000, 0, 1, 32'h1000_0003, 16'h0004, 3'd1, 16'h0004);
    vecs[5]  = mk(0, 16'h0000, 0, 1, 32'h1000_0003, 16'h0004, 3'd2, 16'h0005);
    vecs[6]  = mk(0, 16'h0000, 0, 1, 32'h1000_0003, 16'h0004, 3'd3, 16'h0006);
    vecs[7]  = mk(0, 16'h0000, 0, 1, 32'h1000_0003, 16'h0004, 3'd4, 16'h0007);
    vecs[8]  = mk(0, 16'h0000, 0, 1, 32'h1000_0003, 16'h0004, 3'd4, 16'h0007);
    vecs[9]  = mk(0, 16'h0000, 1, 1, 32'h1000_0003, 16'h0004, 3'd4, 16'h0007);
    vecs[10] = mk(0, 16'h0000, 1, 1, 32'h1000_0004, 16'h0005, 3'd4, 16'h0008);
    vecs[11] = mk(1, 16'h0040, 1, 0, 32'h0,         16'h0000, 3'd4, 16'h0009);
    vecs[12] = mk(1, 16'h0080, 1, 0, 32'h0,         16'h0000, 3'd0, 16'h0040);
    vecs[13] = mk(0, 16'h0000, 1, 0, 32'h0,         16'h0000, 3'd0, 16'h0080);
    vecs[14] = mk(0, 16'h0000, 1, 1, 32'h1000_0080, 16'h0081, 3'd1, 16'h0081);
    vecs[15] = mk(0, 16'h0000, 1, 1, 32'h1000_0081, 16'h0082, 3'd1, 16'h0082);

    w_addr[0] = 16'hFFFE; w_addr[1] = 16'hFFFF; w_addr[2] = 16'h0000; w_addr[3] = 16'h0001;
    w_pc1[0]  = 16'h0000; w_pc1[1]  = 16'hFFFF; w_pc1[2]  = 16'h0000; w_pc1[3]  = 16'h0001;

    rst = 1'b0; redirect = 1'b0; redirect_pc = 16'h0000; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_addr", 32'(imem_addr), 32'h0000);
    check("rst_addr_w", 32'(w_imem_addr), 32'hFFFE);

    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (i == 0) rst = 1'b1;
      redirect    = vecs[i].redirect;
      redirect_pc = vecs[i].rpc;
      out_ready   = vecs[i].rdy;
      #1;
      check($sformatf("v%0d_valid", i), 32'(out_valid), 32'(vecs[i].valid));
      check($sformatf("v%0d_count", i), 32'(count), 32'(vecs[i].cnt));
      check($sformatf("v%0d_addr", i), 32'(imem_addr), 32'(vecs[i].addr));
      if (vecs[i].valid) begin
        check($sformatf("v%0d_inst", i), out_inst, vecs[i].inst);
        check($sformatf("v%0d_pc1", i), 32'(out_pc_plus1), 32'(vecs[i].pc1));
      end
      if (i < 4) begin
        check($sformatf("w%0d_addr", i), 32'(w_imem_addr), 32'(w_addr[i]));
        if (i > 0) check($sformatf("w%0d_pc1", i), 32'(w_out_pc_plus1), 32'(w_pc1[i]));
      end
    end

    // Redirect with three entries queued and out_ready high: no transfer, then restart at target.
    @(negedge clk); rst = 1'b0; redirect = 1'b0; out_ready = 1'b0;
    @(negedge clk); rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("a_count3", 32'(count), 32'd3);
    redirect = 1'b1; redirect_pc = 16'h0040; out_ready = 1'b1;
    #1;
    check("a_redir_valid", 32'(out_valid), 32'd0);
    check("a_redir_count", 32'(count), 32'd3);
    @(negedge clk); redirect = 1'b0; #1;
    check("a_after_count", 32'(count), 32'd0);
    check("a_after_valid", 32'(out_valid), 32'd0);
    check("a_after_addr", 32'(imem_addr), 32'h0040);
    @(negedge clk); #1;
    check("a_tgt_valid", 32'(out_valid), 32'd1);
    check("a_tgt_inst", out_inst, 32'h1000_0040);
    check("a_tgt_pc1", 32'(out_pc_plus1), 32'h0041);

    // Async reset between edges mid-stream takes effect before the next edge.
    @(posedge clk); #2 rst = 1'b0; #1;
    check("b_async_valid", 32'(out_valid), 32'd0);
    check("b_async_count", 32'(count), 32'd0);
    check("b_async_addr", 32'(imem_addr), 32'h0000);
    @(negedge clk); rst = 1'b1; #1;
    check("b_rel_count", 32'(count), 32'd0);
    check("b_rel_addr", 32'(imem_addr), 32'h0000);
    @(negedge clk); #1;
    check("b_restart_valid", 32'(out_valid), 32'd1);
    check("b_restart_inst", out_inst, 32'h1000_0000);
    check("b_restart_pc1", 32'(out_pc_plus1), 32'h0001);

    // Stall ten cycles to fill, then stream twenty cycles at full occupancy.
    @(negedge clk); rst = 1'b0; out_ready = 1'b0;
    @(negedge clk); rst = 1'b1;
    repeat (10) @(negedge clk);
    #1;
    check("c_full_count", 32'(count), 32'd4);
    check("c_full_addr", 32'(imem_addr), 32'h0004);
    out_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      check($sformatf("c%0d_valid", k), 32'(out_valid), 32'd1);
      check($sformatf("c%0d_count", k), 32'(count), 32'd4);
      check($sformatf("c%0d_inst", k), out_inst, 32'h1000_0000 + 32'(k));
      check($sformatf("c%0d_pc1", k), 32'(out_pc_plus1), 32'(k + 1));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
